// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input that idles high; resets to 1.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_ff1;
  logic r_ff2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ff1 <= 1'b1;
      r_ff2 <= 1'b1;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver, 8 data bits + parity + 1 stop, mid-bit sampling with error flags.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit, decision one clock later.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  input  logic       parity_mode,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int SLIP = 1;
`else
  localparam int SLIP = 0;
`endif
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT - 1 + SLIP);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      r_state;
  uart_state_e      w_nextState;
  logic [CNT_W-1:0] r_baudCnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_parityMode;
  logic             r_parityErr;
  logic             w_rxS;
  logic             w_sample;
  logic             w_tick;

  uart_sync2 u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (rx_line),
    .o_q   (w_rxS)
  );

`ifdef UART_RX_MAJORITY_EN
  logic r_hist1;
  logic r_hist2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist1 <= 1'b1;
      r_hist2 <= 1'b1;
    end else begin
      r_hist1 <= w_rxS;
      r_hist2 <= r_hist1;
    end
  end

  assign w_sample = (w_rxS & r_hist1) | (w_rxS & r_hist2) | (r_hist1 & r_hist2);
`else
  assign w_sample = w_rxS;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (!w_rxS) w_nextState = START;
      START:   if (w_tick) w_nextState = w_sample ? IDLE : DATA;
      DATA:    if (w_tick && (r_bitIdx == 3'd7)) w_nextState = PARITY;
      PARITY:  if (w_tick) w_nextState = STOP;
      STOP:    if (w_tick) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The start bit is confirmed half a bit in; every later sample is a whole bit apart.
  always_comb begin
    w_tick  = 1'b0;
    rx_busy = 1'b0;
    unique case (r_state)
      START: w_tick = (r_baudCnt == START_LAST);
      DATA, PARITY, STOP: begin
        w_tick  = (r_baudCnt == BIT_LAST);
        rx_busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baudCnt    <= '0;
      r_bitIdx     <= 3'd0;
      r_shift      <= 8'h00;
      r_parityMode <= 1'b0;
      r_parityErr  <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if ((r_state == IDLE) || w_tick) r_baudCnt <= '0;
      else                             r_baudCnt <= r_baudCnt + 1'b1;
      if (w_tick) begin
        unique case (r_state)
          START: begin
            r_parityMode <= parity_mode;
            r_bitIdx     <= 3'd0;
          end
          DATA: begin
            r_shift[r_bitIdx] <= w_sample;
            if (r_bitIdx != 3'd7) r_bitIdx <= r_bitIdx + 3'd1;
          end
          PARITY: r_parityErr <= (w_sample != ((^r_shift) ^ r_parityMode));
          STOP: begin
            rx_valid   <= 1'b1;
            rx_data    <= r_shift;
            parity_err <= r_parityErr;
            frame_err  <= ~w_sample;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity: table of serial frames plus latency, glitch,
// mid-frame reset and (with UART_RX_MAJORITY_EN) spike-rejection sequences.
module tb_uart_rx_parity;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 3_125_000;
  localparam int CPB       = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int SLIP = 1;
`else
  localparam int SLIP = 0;
`endif
  // Start-bit fall to first cycle with rx_valid: 2 sync + 10.5 bits + 1.
  localparam int EXP_LAT = 2 + (21 * CPB) / 2 + 1 + SLIP;
  localparam int NVEC    = 8;

  typedef struct {
    logic [7:0] data;
    logic       mode;
    logic       par;
    logic       stop;
    int         gap;
    logic [7:0] expData;
    logic       expPerr;
    logic       expFerr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line;
  logic       parity_mode;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int      compared   = 0;
  int      mismatched = 0;
  int      validCycles = 0;
  int      busyCycles  = 0;
  rx_rec_t rxQ[$];
  vec_t    vec[NVEC];

  uart_rx_parity #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_line     (rx_line),
    .parity_mode (parity_mode),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #10 clk = ~clk;

  // Record every strobe and busy cycle on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rx_valid) begin
      validCycles++;
      rxQ.push_back('{rx_data, parity_err, frame_err});
    end
    if (rx_busy) busyCycles++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic driveLevel(input logic v, input int n);
    rx_line = v;
    repeat (n) @(negedge clk);
  endtask

  // Serialise one frame starting now; spikeAt forces a single low cycle (-1 = none).
  task automatic sendFrame(input logic [7:0] d, input logic par, input logic stop, input int spikeAt);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int c = 0; c < 11 * CPB; c++) begin
      rx_line = (c == spikeAt) ? 1'b0 : bits[c / CPB];
      @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    parity_mode = v.mode;
    sendFrame(v.data, v.par, v.stop, -1);
    driveLevel(1'b1, v.gap);
  endtask

  initial begin
    int b0;
    int v0;
    int q0;

    vec[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 2 * CPB, 8'hA5, 1'b0, 1'b0};
    vec[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 0,       8'hA5, 1'b0, 1'b0};
    vec[2] = '{8'h5A, 1'b1, 1'b1, 1'b1, 2 * CPB, 8'h5A, 1'b0, 1'b0};
    vec[3] = '{8'h01, 1'b0, 1'b0, 1'b1, 2 * CPB, 8'h01, 1'b1, 1'b0};
    vec[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 2 * CPB, 8'h3C, 1'b0, 1'b1};
    vec[5] = '{8'hC3, 1'b0, 1'b0, 1'b1, 2 * CPB, 8'hC3, 1'b0, 1'b0};
    vec[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 2 * CPB, 8'h80, 1'b0, 1'b0};
    vec[7] = '{8'h00, 1'b1, 1'b0, 1'b1, 2 * CPB, 8'h00, 1'b1, 1'b0};

    rst         = 1'b1;
    rx_line     = 1'b1;
    parity_mode = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 0);
    checkOutput("reset_parity_err", parity_err, 0);
    checkOutput("reset_frame_err", frame_err, 0);
    checkOutput("reset_rx_busy", rx_busy, 0);
    rst = 1'b0;
    driveLevel(1'b1, 2 * CPB);

    // First frame also measures start-edge-to-strobe latency.
    fork
      applyStimulus(vec[0]);
      begin
        int k;
        @(negedge clk);
        k = 1;
        while (!rx_valid && k < 400) begin
          @(negedge clk);
          k++;
        end
        checkOutput("latency", k, EXP_LAT);
      end
    join
    for (int i = 1; i < NVEC; i++) applyStimulus(vec[i]);
    driveLevel(1'b1, 2 * CPB);

    checkOutput("strobe_cycles", validCycles, NVEC);
    checkOutput("frames_received", rxQ.size(), NVEC);
    for (int i = 0; i < NVEC; i++) begin
      if (i < rxQ.size()) begin
        checkOutput($sformatf("v%0d_data", i), rxQ[i].data, vec[i].expData);
        checkOutput($sformatf("v%0d_perr", i), rxQ[i].perr, vec[i].expPerr);
        checkOutput($sformatf("v%0d_ferr", i), rxQ[i].ferr, vec[i].expFerr);
      end
    end
    checkOutput("hold_rx_data", rx_data, vec[NVEC-1].expData);
    checkOutput("idle_rx_busy", rx_busy, 0);

    // Short low glitch on an idle line must be rejected as a false start.
    b0 = busyCycles;
    v0 = validCycles;
    driveLevel(1'b0, 5);
    driveLevel(1'b1, 3 * CPB);
    checkOutput("glitch_no_strobe", validCycles - v0, 0);
    checkOutput("glitch_no_busy", busyCycles - b0, 0);
    checkOutput("glitch_state_idle", int'(dut.r_state), 0);

    // Reset in the middle of data bit 4 of 8'hFF.
    parity_mode = 1'b0;
    driveLevel(1'b0, CPB);
    driveLevel(1'b1, 4 * CPB + 4);
    checkOutput("mid_frame_busy", rx_busy, 1);
    checkOutput("mid_frame_bit_idx", int'(dut.r_bitIdx), 4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rx_data", rx_data, 8'h00);
    checkOutput("midrst_rx_valid", rx_valid, 0);
    checkOutput("midrst_parity_err", parity_err, 0);
    checkOutput("midrst_frame_err", frame_err, 0);
    checkOutput("midrst_rx_busy", rx_busy, 0);
    checkOutput("midrst_state", int'(dut.r_state), 0);
    rst = 1'b0;
    driveLevel(1'b1, 2 * CPB);
    q0 = rxQ.size();
    sendFrame(8'h81, 1'b0, 1'b1, -1);
    driveLevel(1'b1, 2 * CPB);
    checkOutput("after_rst_frames", rxQ.size() - q0, 1);
    if (rxQ.size() > q0) begin
      checkOutput("after_rst_data", rxQ[q0].data, 8'h81);
      checkOutput("after_rst_perr", rxQ[q0].perr, 0);
      checkOutput("after_rst_ferr", rxQ[q0].ferr, 0);
    end

`ifdef UART_RX_MAJORITY_EN
    // A one-clock low spike exactly at the mid-bit of data bit 3 is outvoted.
    q0 = rxQ.size();
    sendFrame(8'hFF, 1'b0, 1'b1, 4 * CPB + 8);
    driveLevel(1'b1, 2 * CPB);
    checkOutput("spike_frames", rxQ.size() - q0, 1);
    if (rxQ.size() > q0) begin
      checkOutput("spike_data", rxQ[q0].data, 8'hFF);
      checkOutput("spike_perr", rxQ[q0].perr, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
